axis_dot_param: RTL and testbench
=================================

Name: axis_dot_param

Overview:
- Parametrised successor to the fixed 4x4 AXI4-Stream dot-product block: computes y = x·W (row vector x of ROWS elements times a ROWS×COLS matrix W) and streams out COLS results.
- Adds a runtime-loadable weight matrix: the input stream carries a weight-load frame tagged by TUSER. The matrix is no longer a constant.
- Arithmetic is signed fixed-point with a configurable width and binary point. Results saturate to the output width.
- Sits between the DMA MM2S and S2MM streams in the accelerator overlay.

Parameters:
- ROWS, 4, input vector length; also the number of W rows.
- COLS, 4, output vector length; also the number of W columns.
- DATA_W, 32, width of the signed two's-complement words on both streams.
- FRAC_W, 16, number of fractional bits (default format Q16.16).

Ports:
- aclk  in  1  single clock; all logic on its rising edge.
- areset  in  1  reset, synchronous, active-high.
- INPUT_AXIS_TDATA  in  DATA_W  vector element or weight word.
- INPUT_AXIS_TUSER  in  1  frame type, sampled on the frame's first beat: 1 = weight load, 0 = vector.
- INPUT_AXIS_TLAST  in  1  end of frame.
- INPUT_AXIS_TVALID  in  1  input beat valid.
- INPUT_AXIS_TREADY  out  1  block can accept an input beat.
- OUTPUT_AXIS_TDATA  out  DATA_W  result y[j].
- OUTPUT_AXIS_TLAST  out  1  high on y[COLS-1].
- OUTPUT_AXIS_TVALID  out  1  output beat valid.
- OUTPUT_AXIS_TREADY  in  1  downstream can accept a beat.
- frame_err  out  1  sticky flag: frame length and TLAST disagreed.

Behaviour:
- Reset (areset=1 at a rising edge):
  - State → IDLE; all counters 0; accumulators 0; W entries all 0.
  - OUTPUT_AXIS_TVALID, OUTPUT_AXIS_TLAST and OUTPUT_AXIS_TDATA = 0; frame_err = 0; INPUT_AXIS_TREADY = 0.
  - Reset asserted mid-frame or mid-output discards all partial state, including any partial weight load. No output beat completes while reset is high.
- Handshake:
  - A beat transfers only at a rising edge where VALID && READY.
  - OUTPUT_AXIS_TDATA, OUTPUT_AXIS_TLAST and OUTPUT_AXIS_TVALID are registered and held stable while TVALID=1 && TREADY=0.
- State IDLE:
  - TREADY=1.
  - First accepted beat: TUSER=1 → LOAD_W; TUSER=0 → ACCUM. The beat itself is consumed as element 0.
- State LOAD_W:
  - TREADY=1.
  - Beat k (0..ROWS*COLS-1) is written to W[k/COLS][k%COLS], i.e. row-major.
  - After beat ROWS*COLS-1 → IDLE. No output is produced for a weight-load frame.
- State ACCUM:
  - TREADY=1.
  - Beat i (0..ROWS-1) updates every column in one cycle: acc[j] += (x_i * W[i][j]) >>> FRAC_W, for all j.
  - The product is 2*DATA_W bits. The shift is arithmetic (truncation toward −inf).
  - acc width is 2*DATA_W + $clog2(ROWS), so no internal overflow occurs.
  - After beat ROWS-1 → OUTPUT.
- State OUTPUT:
  - TREADY=0.
  - Streams y[0]..y[COLS-1], with TLAST on y[COLS-1].
  - y[j] = acc[j] saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Latency: OUTPUT_AXIS_TVALID rises in the cycle after the edge that accepted x[ROWS-1]. With TREADY held high, one beat per cycle.
  - After the TLAST beat is accepted: accumulators clear → IDLE, and TREADY=1 on the next cycle.
- Frame-length checking (frame length = ROWS*COLS for a weight load, ROWS for a vector):
  - Early TLAST (before the final beat): the frame terminates and frame_err=1.
    - Vector frame: missing x terms are treated as 0, then → OUTPUT.
    - Weight frame: unwritten W entries keep their old values, then → IDLE.
  - TLAST missing on the final beat: the frame still ends on count and frame_err=1. The next beat starts a new frame.
  - frame_err clears only on reset.
- TUSER is ignored on all beats except a frame's first beat.
- Back-to-back vector frames are allowed. Throughput is ROWS + COLS cycles per frame when both streams are never stalled.

Test Plan:
- Identity load: load W with 2.0 (0x00020000) on the diagonal and 0 elsewhere; send vector 0.5, 1.0, 1.5, 2.0 → y = 0x00010000, 0x00020000, 0x00030000, 0x00040000; TLAST on the 4th beat; frame_err=0.
- Full matrix: load all W entries as 1.0 (0x00010000); send x = 1, 2, 3, 4 → every y = 0x000A0000; TVALID high one cycle after x[3] is accepted.
- Saturation:
  - All W and all x = 0x7FFF0000 → every y = 0x7FFFFFFF.
  - Same with W = 0x80010000 → every y = 0x80000000.
- Backpressure and reset: hold OUTPUT_AXIS_TREADY=0 for 5 cycles mid-output → TDATA/TLAST stay constant and INPUT_AXIS_TREADY stays 0. Then assert areset during output → TVALID=0 next cycle; W reads back as zero (vector 1, 2, 3, 4 gives all-zero y).
- Early TLAST: with the all-1.0 W, send x = 1, 2, 3 with TLAST on the 3rd beat → y all 0x00060000; frame_err=1 and remains 1 through the next correct frame.
- Missing TLAST: send a 4-word vector with no TLAST → outputs correct, frame_err=1; a following correctly framed vector is processed normally.

Source files
------------

// File: rtl/axis_dot_param_if.sv
// AXI4-Stream bundle for the dot-product block: data, frame-type tag, end-of-frame and handshake.
// The master drives payload and valid; the slave drives ready.
interface axis_dot_param_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_dot_param.sv
// Streaming y = x·W with a runtime-loadable ROWSxCOLS signed fixed-point weight matrix.
// Weight frames (TUSER=1 on first beat) fill W row-major; vector frames produce COLS saturated results.
module axis_dot_param #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic              aclk,
  input  logic              areset,
  axis_dot_param_if.slave   input_axis,
  axis_dot_param_if.master  output_axis,
  output logic              frame_err
);

  localparam int NW     = ROWS * COLS;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(ROWS);
  localparam int CNT_W  = $clog2(NW + 1);
  localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int OIDX_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_W, ACCUM, OUTPUT} state_t;

  state_t state, state_next;
  logic   rdy;

  logic               take;
  logic [CNT_W-1:0]   beat_idx;
  logic [CNT_W-1:0]   last_idx;
  logic               is_wload;
  logic               last_beat;
  logic               frame_end;
  logic               len_err;
  logic               out_fire;

  logic [CNT_W-1:0]          cnt;
  logic [OIDX_W-1:0]         oidx;
  logic signed [DATA_W-1:0]  w        [NW];
  logic signed [ACC_W-1:0]   acc      [COLS];
  logic signed [ACC_W-1:0]   acc_next [COLS];

  logic [DATA_W-1:0] out_tdata;
  logic              out_tlast;
  logic              out_tvalid;

  // Full-precision product, arithmetic shift back to the binary point (rounds toward -inf).
  function automatic logic signed [ACC_W-1:0] mul_shift(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    p = p >>> FRAC_W;
    return ACC_W'(p);
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] max_d;
    logic signed [DATA_W-1:0] min_d;
    max_d = {1'b0, {(DATA_W-1){1'b1}}};
    min_d = {1'b1, {(DATA_W-1){1'b0}}};
    if (v > ACC_W'(max_d))      return max_d;
    else if (v < ACC_W'(min_d)) return min_d;
    else                        return v[DATA_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] w_idx(input logic [CNT_W-1:0] r, input int c);
    return IDX_W'(int'(r) * COLS + c);
  endfunction

  assign take     = input_axis.tvalid && rdy;
  assign out_fire = out_tvalid && output_axis.tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      rdy   <= 1'b0;
    end else begin
      state <= state_next;
      rdy   <= (state_next != OUTPUT);
    end
  end

  always_comb begin
    beat_idx   = (state == IDLE) ? '0 : cnt;
    is_wload   = (state == IDLE) ? input_axis.tuser : (state == LOAD_W);
    last_idx   = is_wload ? CNT_W'(NW - 1) : CNT_W'(ROWS - 1);
    last_beat  = (beat_idx == last_idx);
    frame_end  = last_beat || input_axis.tlast;
    len_err    = (last_beat != input_axis.tlast);
    state_next = state;
    if (state == OUTPUT) begin
      if (out_fire && out_tlast) state_next = IDLE;
    end else if (take) begin
      if (frame_end) state_next = is_wload ? IDLE : OUTPUT;
      else           state_next = is_wload ? LOAD_W : ACCUM;
    end
  end

  // Every column is updated from the same x element in a single cycle.
  always_comb begin
    for (int j = 0; j < COLS; j++) begin
      acc_next[j] = acc[j];
      if (take && !is_wload)
        acc_next[j] = acc[j] + mul_shift(input_axis.tdata, w[w_idx(beat_idx, j)]);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt        <= '0;
      oidx       <= '0;
      frame_err  <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tvalid <= 1'b0;
      for (int i = 0; i < NW; i++)   w[i]   <= '0;
      for (int j = 0; j < COLS; j++) acc[j] <= '0;
    end else begin
      if (take) begin
        if (is_wload) w[IDX_W'(beat_idx)] <= input_axis.tdata;
        for (int j = 0; j < COLS; j++) acc[j] <= acc_next[j];
        cnt <= frame_end ? '0 : beat_idx + 1'b1;
        if (len_err) frame_err <= 1'b1;
        // y[0] is taken from the sum that includes the beat accepted on this edge.
        if (frame_end && !is_wload) begin
          out_tvalid <= 1'b1;
          out_tdata  <= sat(acc_next[0]);
          out_tlast  <= (COLS == 1);
          oidx       <= OIDX_W'(1);
        end
      end
      if (state == OUTPUT && out_fire) begin
        if (out_tlast) begin
          out_tvalid <= 1'b0;
          out_tlast  <= 1'b0;
          out_tdata  <= '0;
          oidx       <= '0;
          for (int j = 0; j < COLS; j++) acc[j] <= '0;
        end else begin
          out_tdata <= sat(acc[oidx]);
          out_tlast <= (oidx == OIDX_W'(COLS - 1));
          oidx      <= oidx + 1'b1;
        end
      end
    end
  end

  assign input_axis.tready  = rdy;
  assign output_axis.tdata  = out_tdata;
  assign output_axis.tuser  = 1'b0;
  assign output_axis.tlast  = out_tlast;
  assign output_axis.tvalid = out_tvalid;

endmodule

// File: tb/tb_axis_dot_param.sv
// Directed bench for axis_dot_param (4x4, Q16.16): weight loads, products, saturation,
// backpressure, reset mid-output and frame-length errors.
module tb_axis_dot_param;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic frame_err;
  int   errors = 0;
  int   checks = 0;

  axis_dot_param_if #(.DATA_W(32)) in_if ();
  axis_dot_param_if #(.DATA_W(32)) out_if ();

  axis_dot_param #(.ROWS(4), .COLS(4), .DATA_W(32), .FRAC_W(16)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .input_axis  (in_if.slave),
    .output_axis (out_if.master),
    .frame_err   (frame_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d, input logic u, input logic l, input string tag);
    int n;
    n = 0;
    in_if.tdata  = d;
    in_if.tuser  = u;
    in_if.tlast  = l;
    in_if.tvalid = 1'b1;
    while (!in_if.tready && n < 40) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_rdy_wait"}, 64'(n < 40), 64'd1);
    @(negedge aclk);
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 1'b0;
  endtask

  task automatic load_w(input logic [31:0] diag, input logic [31:0] off);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send((r == c) ? diag : off, (r == 0 && c == 0), (r == 3 && c == 3), "wload");
  endtask

  task automatic send_vec(input logic [31:0] x[4], input int n, input logic with_last,
                          input string tag);
    for (int i = 0; i < n; i++)
      send(x[i], 1'b0, with_last && (i == n - 1), tag);
    check({tag, "_latency"}, 64'(out_if.tvalid), 64'd1);
  endtask

  task automatic recv(input logic [31:0] e[4], input string tag);
    int n;
    out_if.tready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (!out_if.tvalid && n < 40) begin
        @(negedge aclk);
        n++;
      end
      check($sformatf("%s_v%0d", tag, j), 64'(out_if.tvalid), 64'd1);
      check($sformatf("%s_y%0d", tag, j), 64'(out_if.tdata), 64'(e[j]));
      check($sformatf("%s_last%0d", tag, j), 64'(out_if.tlast), 64'(j == 3));
      @(negedge aclk);
    end
    check({tag, "_vld_drop"}, 64'(out_if.tvalid), 64'd0);
    check({tag, "_in_rdy"}, 64'(in_if.tready), 64'd1);
  endtask

  initial begin
    logic [31:0] x[4];
    logic [31:0] e[4];
    in_if.tdata   = '0;
    in_if.tuser   = 1'b0;
    in_if.tlast   = 1'b0;
    in_if.tvalid  = 1'b0;
    out_if.tready = 1'b1;

    // reset state
    repeat (2) @(negedge aclk);
    check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check("rst_tlast", 64'(out_if.tlast), 64'd0);
    check("rst_tdata", 64'(out_if.tdata), 64'd0);
    check("rst_in_rdy", 64'(in_if.tready), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("idle_in_rdy", 64'(in_if.tready), 64'd1);

    // identity x2.0
    load_w(32'h0002_0000, 32'h0);
    x = '{32'h0000_8000, 32'h0001_0000, 32'h0001_8000, 32'h0002_0000};
    send_vec(x, 4, 1'b1, "ident");
    e = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
    recv(e, "ident");
    check("ident_ferr", 64'(frame_err), 64'd0);

    // all-ones matrix
    load_w(32'h0001_0000, 32'h0001_0000);
    x = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
    send_vec(x, 4, 1'b1, "ones");
    e = '{4{32'h000A_0000}};
    recv(e, "ones");

    // saturation both directions
    load_w(32'h7FFF_0000, 32'h7FFF_0000);
    x = '{4{32'h7FFF_0000}};
    send_vec(x, 4, 1'b1, "satp");
    e = '{4{32'h7FFF_FFFF}};
    recv(e, "satp");
    load_w(32'h8001_0000, 32'h8001_0000);
    send_vec(x, 4, 1'b1, "satn");
    e = '{4{32'h8000_0000}};
    recv(e, "satn");
    check("sat_ferr", 64'(frame_err), 64'd0);

    // backpressure then reset mid-output
    load_w(32'h0001_0000, 32'h0001_0000);
    out_if.tready = 1'b0;
    x = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
    send_vec(x, 4, 1'b1, "bp");
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_data%0d", c), 64'(out_if.tdata), 64'h000A_0000);
      check($sformatf("bp_hold_last%0d", c), 64'(out_if.tlast), 64'd0);
      check($sformatf("bp_hold_vld%0d", c), 64'(out_if.tvalid), 64'd1);
      check($sformatf("bp_in_rdy%0d", c), 64'(in_if.tready), 64'd0);
      @(negedge aclk);
    end
    out_if.tready = 1'b1;
    @(negedge aclk);
    check("bp_y1_data", 64'(out_if.tdata), 64'h000A_0000);
    check("bp_y1_last", 64'(out_if.tlast), 64'd0);
    areset = 1'b1;
    @(negedge aclk);
    check("mid_rst_vld", 64'(out_if.tvalid), 64'd0);
    check("mid_rst_data", 64'(out_if.tdata), 64'd0);
    areset = 1'b0;
    send_vec(x, 4, 1'b1, "wzero");
    e = '{4{32'h0}};
    recv(e, "wzero");

    // early TLAST: x3 missing, treated as 0
    load_w(32'h0001_0000, 32'h0001_0000);
    check("early_ferr_before", 64'(frame_err), 64'd0);
    send_vec(x, 3, 1'b1, "early");
    e = '{4{32'h0006_0000}};
    recv(e, "early");
    check("early_ferr", 64'(frame_err), 64'd1);
    send_vec(x, 4, 1'b1, "after_early");
    e = '{4{32'h000A_0000}};
    recv(e, "after_early");
    check("early_ferr_sticky", 64'(frame_err), 64'd1);

    // missing TLAST, then a correctly framed vector with a stray TUSER mid-frame
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("miss_ferr_clear", 64'(frame_err), 64'd0);
    load_w(32'h0001_0000, 32'h0001_0000);
    send_vec(x, 4, 1'b0, "miss");
    e = '{4{32'h000A_0000}};
    recv(e, "miss");
    check("miss_ferr", 64'(frame_err), 64'd1);
    send(32'h0001_0000, 1'b0, 1'b0, "next0");
    send(32'h0001_0000, 1'b1, 1'b0, "next1");
    send(32'h0001_0000, 1'b0, 1'b0, "next2");
    send(32'h0001_0000, 1'b0, 1'b1, "next3");
    check("next_latency", 64'(out_if.tvalid), 64'd1);
    e = '{4{32'h0004_0000}};
    recv(e, "next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
